// File: rtl/bus_cycle_ctrl.sv
// Chip-select and wait-state controller for an 8088-style peripheral bus.
// Decodes the ALE-latched address against programmable regions and paces READY.
module bus_cycle_ctrl #(
  parameter int unsigned AddressWidth = 20,
  parameter int unsigned NUM_REGIONS  = 4,
  parameter int unsigned WAIT_W       = 3,
  parameter int unsigned TIMEOUT      = 15,
  localparam int unsigned IdxW        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    ALE,
  input  logic                    IOM,
  input  logic                    RD_N,
  input  logic                    WR_N,
  input  logic [AddressWidth-1:0] Address,
  input  logic                    cfg_we,
  input  logic [IdxW-1:0]         cfg_idx,
  input  logic                    cfg_en,
  input  logic                    cfg_iom,
  input  logic [AddressWidth-1:0] cfg_base,
  input  logic [AddressWidth-1:0] cfg_mask,
  input  logic [WAIT_W-1:0]       cfg_wait,
  output logic [NUM_REGIONS-1:0]  sel,
  output logic                    READY,
  output logic                    bus_err,
  output logic                    cycle_active
);

  localparam int unsigned TcntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_END} state_t;

  logic [NUM_REGIONS-1:0]  r_en;
  logic [NUM_REGIONS-1:0]  r_ciom;
  logic [AddressWidth-1:0] r_base [NUM_REGIONS];
  logic [AddressWidth-1:0] r_mask [NUM_REGIONS];
  logic [WAIT_W-1:0]       r_cwait [NUM_REGIONS];

  state_t                  r_state;
  logic                    r_hit;
  logic [IdxW-1:0]         r_idx;
  logic [WAIT_W-1:0]       r_wait;
  logic [WAIT_W-1:0]       r_wcnt;
  logic [TcntW-1:0]        r_tcnt;
  logic                    r_first;
  logic [NUM_REGIONS-1:0]  r_sel;
  logic                    r_ready;
  logic                    r_err;
  logic                    r_active;

  logic                    w_hit;
  logic [IdxW-1:0]         w_idx;
  logic [WAIT_W-1:0]       w_wait;
  logic [NUM_REGIONS-1:0]  w_onehot;
  logic                    w_any_strb;
  logic                    w_both_strb;

  assign w_any_strb  = !RD_N || !WR_N;
  assign w_both_strb = !RD_N && !WR_N;
  assign w_onehot    = r_hit ? (NUM_REGIONS'(1) << r_idx) : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_en   <= '0;
      r_ciom <= '0;
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        r_base[i]  <= '0;
        r_mask[i]  <= '0;
        r_cwait[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        if (cfg_idx == IdxW'(i)) begin
          r_en[i]    <= cfg_en;
          r_ciom[i]  <= cfg_iom;
          r_base[i]  <= cfg_base;
          r_mask[i]  <= cfg_mask;
          r_cwait[i] <= cfg_wait;
        end
      end
    end
  end

  // Ascending scan with a found flag gives lowest-index priority.
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_wait = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!w_hit && r_en[i] && (r_ciom[i] == IOM) &&
          (((Address ^ r_base[i]) & r_mask[i]) == '0)) begin
        w_hit  = 1'b1;
        w_idx  = IdxW'(i);
        w_wait = r_cwait[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_hit    <= 1'b0;
      r_idx    <= '0;
      r_wait   <= '0;
      r_wcnt   <= '0;
      r_tcnt   <= '0;
      r_first  <= 1'b0;
      r_sel    <= '0;
      r_ready  <= 1'b1;
      r_err    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ALE) begin
            r_state <= S_ADDR;
            r_hit   <= w_hit;
            r_idx   <= w_idx;
            r_wait  <= w_wait;
            r_tcnt  <= TcntW'(1);
          end
        end
        S_ADDR: begin
          if (w_both_strb) begin
            r_err    <= 1'b1;
            r_sel    <= '0;
            r_active <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_sel    <= w_onehot;
            r_active <= 1'b1;
            if (w_any_strb) begin
              r_state <= S_STROBE;
              r_wcnt  <= r_wait;
              r_first <= 1'b1;
            end else if (r_tcnt == TcntW'(TIMEOUT)) begin
              r_err    <= 1'b1;
              r_sel    <= '0;
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + TcntW'(1);
            end
          end
        end
        S_STROBE: begin
          r_first <= 1'b0;
          if (w_both_strb) begin
            r_err    <= 1'b1;
            r_sel    <= '0;
            r_active <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            // A miss reports once, on the first cycle spent in STROBE.
            if (r_first && !r_hit) r_err <= 1'b1;
            if (!w_any_strb) begin
              r_ready <= 1'b1;
              r_state <= S_END;
            end else begin
              r_ready <= (r_wcnt == '0);
              if (r_wcnt != '0) r_wcnt <= r_wcnt - WAIT_W'(1);
            end
          end
        end
        S_END: begin
          r_sel    <= '0;
          r_active <= 1'b0;
          r_ready  <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel          = r_sel;
  assign READY        = r_ready;
  assign bus_err      = r_err;
  assign cycle_active = r_active;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl: stimulus queues expected bus-cycle summaries,
// a monitor rebuilds each observed cycle from the outputs and compares.
module tb_bus_cycle_ctrl;

  typedef struct {
    int sel;
    int act_first;
    int act_last;
    int sel_first;
    int sel_last;
    int rdy_first;
    int rdy_last;
    int rdy_cnt;
    int err_first;
    int err_cnt;
  } txn_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ALE;
  logic        IOM;
  logic        RD_N;
  logic        WR_N;
  logic [19:0] Address;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  logic        cfg_iom;
  logic [19:0] cfg_base;
  logic [19:0] cfg_mask;
  logic [2:0]  cfg_wait;
  logic [3:0]  sel;
  logic        READY;
  logic        bus_err;
  logic        cycle_active;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   n_txn = 0;
  txn_t expq[$];

  bus_cycle_ctrl #(
    .AddressWidth(20),
    .NUM_REGIONS (4),
    .WAIT_W      (3),
    .TIMEOUT     (15)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .ALE         (ALE),
    .IOM         (IOM),
    .RD_N        (RD_N),
    .WR_N        (WR_N),
    .Address     (Address),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_en      (cfg_en),
    .cfg_iom     (cfg_iom),
    .cfg_base    (cfg_base),
    .cfg_mask    (cfg_mask),
    .cfg_wait    (cfg_wait),
    .sel         (sel),
    .READY       (READY),
    .bus_err     (bus_err),
    .cycle_active(cycle_active)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  function automatic txn_t mk(input int s, input int af, input int al, input int sf, input int sl,
                              input int rf, input int rl, input int rc, input int ef, input int ec);
    txn_t t;
    t.sel = s; t.act_first = af; t.act_last = al; t.sel_first = sf; t.sel_last = sl;
    t.rdy_first = rf; t.rdy_last = rl; t.rdy_cnt = rc; t.err_first = ef; t.err_cnt = ec;
    return t;
  endfunction

  task automatic check_txn(input txn_t g);
    txn_t x;
    string p;
    if (expq.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_txn: got cycle starting at %0d, required none", g.act_first);
      return;
    end
    x = expq.pop_front();
    n_txn++;
    p = $sformatf("txn%0d", n_txn);
    chk({p, ".sel"},       g.sel,       x.sel);
    chk({p, ".act_first"}, g.act_first, x.act_first);
    chk({p, ".act_last"},  g.act_last,  x.act_last);
    chk({p, ".sel_first"}, g.sel_first, x.sel_first);
    chk({p, ".sel_last"},  g.sel_last,  x.sel_last);
    chk({p, ".rdy_first"}, g.rdy_first, x.rdy_first);
    chk({p, ".rdy_last"},  g.rdy_last,  x.rdy_last);
    chk({p, ".rdy_cnt"},   g.rdy_cnt,   x.rdy_cnt);
    chk({p, ".err_first"}, g.err_first, x.err_first);
    chk({p, ".err_cnt"},   g.err_cnt,   x.err_cnt);
  endtask

  // Monitor: a bus cycle is any contiguous run of non-idle outputs.
  txn_t cur;
  bit   in_txn = 1'b0;
  always @(negedge CLK) begin
    if (cycle_active || (sel != 4'b0000) || !READY || bus_err) begin
      if (!in_txn) begin
        cur = mk(0, -1, -1, -1, -1, -1, -1, 0, -1, 0);
        in_txn = 1'b1;
      end
      if (cycle_active) begin
        if (cur.act_first < 0) cur.act_first = cyc;
        cur.act_last = cyc;
      end
      if (sel != 4'b0000) begin
        cur.sel = cur.sel | int'(sel);
        if (cur.sel_first < 0) cur.sel_first = cyc;
        cur.sel_last = cyc;
      end
      if (!READY) begin
        if (cur.rdy_first < 0) cur.rdy_first = cyc;
        cur.rdy_last = cyc;
        cur.rdy_cnt++;
      end
      if (bus_err) begin
        if (cur.err_first < 0) cur.err_first = cyc;
        cur.err_cnt++;
      end
    end else if (in_txn) begin
      in_txn = 1'b0;
      check_txn(cur);
    end
  end

  always @(negedge RESET_N) begin
    #1;
    chk("rst.sel",          int'(sel),          0);
    chk("rst.READY",        int'(READY),        1);
    chk("rst.bus_err",      int'(bus_err),      0);
    chk("rst.cycle_active", int'(cycle_active), 0);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  task automatic cfg_write(input logic [1:0] idx, input logic en, input logic iom,
                           input logic [19:0] base, input logic [19:0] mask, input logic [2:0] wt);
    @(negedge CLK);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_iom = iom;
    cfg_base = base; cfg_mask = mask; cfg_wait = wt;
    @(negedge CLK);
    cfg_we = 1'b0;
  endtask

  // One bus cycle; strobe held low for slen sampled edges. midcfg rewrites region 2
  // with wait 0 on the first strobe cycle.
  task automatic run_cycle(input logic [19:0] a, input logic io, input logic wr, input int slen,
                           input int esel, input int ewait, input bit midcfg);
    int k, s, e;
    @(negedge CLK);
    ALE = 1'b1; Address = a; IOM = io;
    k = cyc + 1;
    @(negedge CLK);
    ALE = 1'b0; Address = 20'hFFFFF;
    if (wr) WR_N = 1'b0; else RD_N = 1'b0;
    s = cyc + 1;
    if (midcfg) begin
      cfg_we = 1'b1; cfg_idx = 2'd2; cfg_en = 1'b1; cfg_iom = 1'b1;
      cfg_base = 20'h00040; cfg_mask = 20'hFFFF0; cfg_wait = 3'd0;
    end
    for (int i = 0; i < slen; i++) begin
      @(negedge CLK);
      cfg_we = 1'b0;
    end
    RD_N = 1'b1; WR_N = 1'b1;
    e = s + slen;
    expq.push_back(mk(esel, k + 1, e,
                      (esel != 0) ? k + 1 : -1, (esel != 0) ? e : -1,
                      (ewait > 0) ? s + 1 : -1, (ewait > 0) ? s + ewait : -1, ewait,
                      (esel == 0) ? s + 1 : -1, (esel == 0) ? 1 : 0));
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    int k, s;
    RESET_N = 1'b1; ALE = 1'b0; IOM = 1'b0; RD_N = 1'b1; WR_N = 1'b1; Address = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_iom = 1'b0;
    cfg_base = '0; cfg_mask = '0; cfg_wait = '0;
    #3 RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    cfg_write(2'd0, 1'b1, 1'b0, 20'h00000, 20'hC0000, 3'd0);
    run_cycle(20'h12345, 1'b0, 1'b0, 2, 4'b0001, 0, 1'b0);
    cfg_write(2'd2, 1'b1, 1'b1, 20'h00040, 20'hFFFF0, 3'd3);
    run_cycle(20'h00045, 1'b1, 1'b1, 5, 4'b0100, 3, 1'b1);
    run_cycle(20'h00045, 1'b1, 1'b1, 2, 4'b0100, 0, 1'b0);
    cfg_write(2'd1, 1'b1, 1'b0, 20'h00010, 20'hFFFFF, 3'd1);
    run_cycle(20'h00010, 1'b0, 1'b0, 3, 4'b0001, 0, 1'b0);
    cfg_write(2'd3, 1'b1, 1'b0, 20'h40000, 20'hC0000, 3'd2);
    run_cycle(20'h4ABCD, 1'b0, 1'b1, 4, 4'b1000, 2, 1'b0);
    run_cycle(20'h80000, 1'b0, 1'b0, 2, 4'b0000, 0, 1'b0);
    run_cycle(20'h00010, 1'b1, 1'b0, 1, 4'b0000, 0, 1'b0);

    // Timeout, with a second ALE mid-cycle that must be ignored.
    @(negedge CLK);
    ALE = 1'b1; Address = 20'h00100; IOM = 1'b0;
    k = cyc + 1;
    @(negedge CLK);
    ALE = 1'b0;
    repeat (2) @(negedge CLK);
    ALE = 1'b1; Address = 20'h80000;
    @(negedge CLK);
    ALE = 1'b0;
    expq.push_back(mk(1, k + 1, k + 14, k + 1, k + 14, -1, -1, 0, k + 15, 1));
    repeat (20) @(negedge CLK);

    // Both strobes low during STROBE aborts.
    @(negedge CLK);
    ALE = 1'b1; Address = 20'h4ABCD; IOM = 1'b0;
    @(negedge CLK);
    ALE = 1'b0; RD_N = 1'b0;
    s = cyc + 1;
    repeat (2) @(negedge CLK);
    WR_N = 1'b0;
    expq.push_back(mk(8, s, s + 1, s, s + 1, s + 1, s + 1, 1, s + 2, 1));
    @(negedge CLK);
    RD_N = 1'b1; WR_N = 1'b1;
    repeat (3) @(negedge CLK);

    // Strobes in IDLE produce nothing.
    RD_N = 1'b0;
    repeat (4) @(negedge CLK);
    RD_N = 1'b1;
    repeat (3) @(negedge CLK);

    // Asynchronous reset while READY is low.
    @(negedge CLK);
    ALE = 1'b1; Address = 20'h4ABCD; IOM = 1'b0;
    @(negedge CLK);
    ALE = 1'b0; RD_N = 1'b0;
    s = cyc + 1;
    expq.push_back(mk(8, s, s + 1, s, s + 1, s + 1, s + 1, 1, -1, 0));
    repeat (3) @(posedge CLK);
    #2 RESET_N = 1'b0;
    @(negedge CLK);
    RD_N = 1'b1;
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    run_cycle(20'h12345, 1'b0, 1'b0, 2, 4'b0000, 0, 1'b0);

    repeat (5) @(negedge CLK);
    chk("queue_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
